pixel_stream_src: RTL and testbench

Synthesizable pixel source that replaces hand-fed stimulus for the CNN `top`.
- Stores NUM_IMGS grayscale images of IMG_W x IMG_H pixels in internal RAM, loaded through a write port.
- On `start`, streams the selected image in raster order over a valid/ready interface.
- Flags row ends and the last pixel, and counts completed frames.
- Sits between the host/loader and the convolution front end, both in on-FPGA demo builds and in regression benches.

---
 rtl/pixel_stream_src.sv | 162 ++++++++++++++++
 tb/tb_pixel_stream_src.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_src.sv
// Pixel source: NUM_IMGS images held in on-chip RAM, streamed in raster order over valid/ready.
// Define PIXSRC_ZERO_PAD_EN to wrap each frame in a PAD-pixel zero border.
module pixel_stream_src #(
    parameter  int IMG_W    = 28,
    parameter  int IMG_H    = 28,
    parameter  int PIX_W    = 8,
    parameter  int NUM_IMGS = 4,
    parameter  int PAD      = 1,
    localparam int NPIX     = IMG_W * IMG_H,
    localparam int ADDR_W   = $clog2(NUM_IMGS * NPIX),
    localparam int SEL_W    = (NUM_IMGS > 1) ? $clog2(NUM_IMGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              start,
    input  logic [SEL_W-1:0]  img_sel,
    output logic              busy,
    output logic              sel_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_row_end,
    output logic              m_last,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

`ifdef PIXSRC_ZERO_PAD_EN
    localparam int PAD_EN = 1;
`else
    localparam int PAD_EN = 0;
`endif
    localparam int OUT_W = IMG_W + 2 * PAD * PAD_EN;
    localparam int OUT_H = IMG_H + 2 * PAD * PAD_EN;
    localparam int TOTAL = NUM_IMGS * NPIX;
    localparam int ROW_W = $clog2(OUT_H + 1);
    localparam int COL_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               sel_err_q, sel_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIX_W-1:0]   rd_data_q;
    logic [PIX_W-1:0]   mem [TOTAL];
    logic               hs;
    logic               wr_ok;
    logic               col_end;
    logic               row_end_q;

    assign busy       = (state_q == PRIME) || (state_q == STREAM);
    assign m_valid    = (state_q == STREAM);
    assign frame_done = (state_q == DONE);
    assign sel_err    = sel_err_q;
    assign frame_cnt  = frame_cnt_q;

    assign col_end   = (col_q == COL_W'(OUT_W - 1));
    assign row_end_q = (row_q == ROW_W'(OUT_H - 1));
    assign m_row_end = m_valid && col_end;
    assign m_last    = m_row_end && row_end_q;
    assign hs        = m_valid && m_ready;
    assign wr_ok     = wr_en && !busy && ({1'b0, wr_addr} < (ADDR_W + 1)'(TOTAL));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        sel_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ({1'b0, img_sel} < (SEL_W + 1)'(NUM_IMGS)) begin
                        base_d  = ADDR_W'(img_sel) * ADDR_W'(NPIX);
                        row_d   = '0;
                        col_d   = '0;
                        state_d = PRIME;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            PRIME: state_d = STREAM;
            STREAM: begin
                if (hs) begin
                    if (m_last) begin
                        state_d = DONE;
                    end else if (col_end) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read address follows the position that will be presented next cycle, so a
    // stalled beat simply re-reads the same word and stays stable.
`ifdef PIXSRC_ZERO_PAD_EN
    logic interior_d, border_q;

    always_comb begin
        interior_d = (row_d >= ROW_W'(PAD)) && (row_d < ROW_W'(PAD + IMG_H)) &&
                     (col_d >= COL_W'(PAD)) && (col_d < COL_W'(PAD + IMG_W));
        rd_addr    = base_d;
        if (interior_d)
            rd_addr = base_d + (ADDR_W'(row_d) - ADDR_W'(PAD)) * ADDR_W'(IMG_W)
                             + (ADDR_W'(col_d) - ADDR_W'(PAD));
    end

    always_ff @(posedge clk) border_q <= !interior_d;

    assign m_data = (m_valid && !border_q) ? rd_data_q : '0;
`else
    always_comb begin
        rd_addr = base_d + ADDR_W'(row_d) * ADDR_W'(IMG_W) + ADDR_W'(col_d);
    end

    assign m_data = m_valid ? rd_data_q : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sel_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sel_err_q   <= sel_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Image RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_pixel_stream_src.sv
// Scoreboard bench for pixel_stream_src: expected beats are queued by the stimulus,
// a negedge monitor compares every presented beat against the queue head.
module tb_pixel_stream_src;

    localparam int IW = 28;
    localparam int IH = 28;
`ifdef PIXSRC_ZERO_PAD_EN
    localparam int P  = 1;
`else
    localparam int P  = 0;
`endif
    localparam int OW = IW + 2 * P;
    localparam int OH = IH + 2 * P;

    typedef struct packed {
        logic [7:0] d;
        logic       re;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, wr_en, start, m_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  img_sel;
    logic        busy, sel_err, m_valid, m_row_end, m_last, frame_done;
    logic [7:0]  m_data;
    logic [15:0] frame_cnt;

    logic        wr_en_s, start_s, m_ready_s;
    logic [4:0]  wr_addr_s;
    logic [7:0]  wr_data_s;
    logic [1:0]  img_sel_s;
    logic        busy_s, sel_err_s, m_valid_s, m_row_end_s, m_last_s, frame_done_s;
    logic [7:0]  m_data_s;
    logic [15:0] frame_cnt_s;

    pixel_stream_src u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .img_sel(img_sel), .busy(busy), .sel_err(sel_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row_end(m_row_end),
        .m_last(m_last), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Three slots so an out-of-range select is representable on a 2-bit img_sel.
    pixel_stream_src #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .NUM_IMGS(3), .PAD(1)) u_small (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .start(start_s), .img_sel(img_sel_s), .busy(busy_s), .sel_err(sel_err_s),
        .m_valid(m_valid_s), .m_ready(m_ready_s), .m_data(m_data_s), .m_row_end(m_row_end_s),
        .m_last(m_last_s), .frame_done(frame_done_s), .frame_cnt(frame_cnt_s)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    last_hs_cyc = -1;
    beat_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t exp_beat(int img, int i);
        beat_t b;
        int r, c, a;
        r = i / OW;
        c = i % OW;
        b.re   = (c == OW - 1);
        b.last = (i == OW * OH - 1);
        if (r < P || r >= P + IH || c < P || c >= P + IW) begin
            b.d = 8'h00;
        end else begin
            a   = img * IW * IH + (r - P) * IW + (c - P);
            b.d = a[7:0];
        end
        return b;
    endfunction

    // Monitor: every presented beat must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got data %0h with empty scoreboard", m_data);
            end else begin
                check("beat_data", m_data, sb[0].d);
                check("beat_row_end", m_row_end, sb[0].re);
                check("beat_last", m_last, sb[0].last);
                if (m_ready) begin
                    if (sb[0].last) last_hs_cyc = cyc;
                    void'(sb.pop_front());
                    hs_count++;
                end
            end
        end
    end

    task automatic start_frame(int img);
        hs_count = 0;
        for (int i = 0; i < OW * OH; i++) sb.push_back(exp_beat(img, i));
        @(posedge clk); #1;
        start   = 1'b1;
        img_sel = 2'(img);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("prime_valid", m_valid, 0);
        check("prime_busy", busy, 1);
        @(negedge clk);
        check("first_valid", m_valid, 1);
    endtask

    task automatic wait_frame(bit toggle, int exp_cnt);
        bit seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (toggle) begin
                @(posedge clk); #1;
                m_ready = !m_ready;
            end
        end
        check("frame_done_seen", seen, 1);
        if (seen) begin
            check("done_timing", cyc, last_hs_cyc + 1);
            check("queue_empty", sb.size(), 0);
            check("done_valid_low", m_valid, 0);
            check("done_busy_low", busy, 0);
            @(negedge clk);
            check("done_pulse_width", frame_done, 0);
            check("frame_cnt", frame_cnt, exp_cnt);
        end
        sb.delete();
        m_ready = 1'b1;
    endtask

    task automatic wait_beats(int n);
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            if (hs_count >= n) break;
        end
        #1;
        check("reach_beat", hs_count >= n, 1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sel_err"}, sel_err, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_row_end"}, m_row_end, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; img_sel = '0; m_ready = 1'b1;
        wr_en_s = 1'b0; wr_addr_s = '0; wr_data_s = '0;
        start_s = 1'b0; img_sel_s = '0; m_ready_s = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load RAM[a] = a[7:0] across all four slots.
        for (int a = 0; a < 4 * IW * IH; a++) begin
            wr_en   = 1'b1;
            wr_addr = 12'(a);
            wr_data = 8'(a);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;

        // Image 0 at full rate.
        start_frame(0);
        wait_frame(1'b0, 1);

        // Image 1 with m_ready alternating; stalled beats are checked against the queue head.
        m_ready = 1'b0;
        start_frame(1);
        wait_frame(1'b1, 2);

        // Image 2 with a start pulse mid-frame that must be ignored.
        start_frame(2);
        wait_beats(300);
        start   = 1'b1;
        img_sel = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_start_sel_err", sel_err, 0);
        check("busy_start_busy", busy, 1);
        wait_frame(1'b0, 3);
        repeat (3) @(negedge clk);
        check("no_restart_valid", m_valid, 0);
        check("no_restart_busy", busy, 0);

        // Image 0 again: a write while busy must be dropped, then reset mid-frame.
        start_frame(0);
        wait_beats(50);
        wr_en   = 1'b1;
        wr_addr = 12'd200;
        wr_data = 8'h55;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_beats(100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("midreset");
        start_frame(0);
        wait_frame(1'b0, 1);

        // Out-of-range select on the three-slot instance.
        @(posedge clk); #1;
        start_s   = 1'b1;
        img_sel_s = 2'd3;
        @(posedge clk); #1;
        start_s = 1'b0;
        @(negedge clk);
        check("sel_err_pulse", sel_err_s, 1);
        check("sel_err_busy", busy_s, 0);
        check("sel_err_valid", m_valid_s, 0);
        @(negedge clk);
        check("sel_err_one_cycle", sel_err_s, 0);
        check("sel_err_valid_after", m_valid_s, 0);
        check("sel_err_busy_after", busy_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
